// File: rtl/sram_axi_bridge_pkg.sv
// sram_axi_bridge_pkg: write FSM encoding, fixed AXI attribute values and port/ID mapping.
package sram_axi_bridge_pkg;

    typedef enum logic [1:0] {WR_IDLE, WR_SEND, WR_RESP} wr_state_t;

    localparam logic [7:0] AXI_LEN    = 8'd0;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_LOCK   = 2'b00;
    localparam logic [3:0] AXI_CACHE  = 4'b0000;
    localparam logic [2:0] AXI_PROT   = 3'b000;

    function automatic logic [7:0] port_to_id(input int p);
        return 8'(p);
    endfunction

endpackage

// File: rtl/sram_axi_bridge_arb.sv
// rr_arbiter: one-hot round-robin arbiter; the pointer moves past the grantee when update is high.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         update,
    output logic [N-1:0] grant
);

    localparam int PW = N > 1 ? $clog2(N) : 1;

    logic [PW-1:0] ptr, ptr_nxt, idx;

    // Scan from lowest priority up so the last hit is the highest-priority requester.
    always_comb begin
        grant   = '0;
        ptr_nxt = ptr;
        idx     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = PW'((int'(ptr) + i) % N);
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                ptr_nxt    = (idx == PW'(N - 1)) ? '0 : idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr <= '0;
        else if (update) ptr <= ptr_nxt;
    end

endmodule

// File: rtl/sram_axi_bridge.sv
// sram_axi_bridge: arbitrates NPORTS SRAM-like masters onto one AXI3 port using single-beat transfers.
module sram_axi_bridge
    import sram_axi_bridge_pkg::*;
#(
    parameter int NPORTS   = 2,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int ID_W     = 4,
    parameter int RD_OUTST = 2
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    output logic [ID_W-1:0]            arid,
    output logic [ADDR_W-1:0]          araddr,
    output logic [7:0]                 arlen,
    output logic [2:0]                 arsize,
    output logic [1:0]                 arburst,
    output logic [1:0]                 arlock,
    output logic [3:0]                 arcache,
    output logic [2:0]                 arprot,
    output logic                       arvalid,
    input  logic                       arready,
    input  logic [ID_W-1:0]            rid,
    input  logic [DATA_W-1:0]          rdata,
    input  logic [1:0]                 rresp,
    input  logic                       rlast,
    input  logic                       rvalid,
    output logic                       rready,
    output logic [ID_W-1:0]            awid,
    output logic [ADDR_W-1:0]          awaddr,
    output logic [7:0]                 awlen,
    output logic [2:0]                 awsize,
    output logic [1:0]                 awburst,
    output logic [1:0]                 awlock,
    output logic [3:0]                 awcache,
    output logic [2:0]                 awprot,
    output logic                       awvalid,
    input  logic                       awready,
    output logic [ID_W-1:0]            wid,
    output logic [DATA_W-1:0]          wdata,
    output logic [DATA_W/8-1:0]        wstrb,
    output logic                       wlast,
    output logic                       wvalid,
    input  logic                       wready,
    input  logic [ID_W-1:0]            bid,
    input  logic [1:0]                 bresp,
    input  logic                       bvalid,
    output logic                       bready,
    input  logic [NPORTS-1:0]          sram_req,
    input  logic [NPORTS-1:0]          sram_wr,
    input  logic [2*NPORTS-1:0]        sram_size,
    input  logic [NPORTS*DATA_W/8-1:0] sram_wstrb,
    input  logic [NPORTS*ADDR_W-1:0]   sram_addr,
    input  logic [NPORTS*DATA_W-1:0]   sram_wdata,
    output logic [NPORTS-1:0]          sram_addr_ok,
    output logic [NPORTS-1:0]          sram_data_ok,
    output logic [NPORTS*DATA_W-1:0]   sram_rdata
);

    localparam int SW  = DATA_W / 8;
    localparam int OFS = $clog2(SW);
    localparam int CW  = $clog2(RD_OUTST + 1);
    localparam int PW  = NPORTS > 1 ? $clog2(NPORTS) : 1;

    wr_state_t         wr_state, wr_state_nxt;
    logic [PW-1:0]     wr_owner, gidx;
    logic              aw_done, w_done, wr_busy;
    logic              rd_gnt, wr_gnt;
    logic [NPORTS-1:0] rd_elig, wr_elig, grant, rd_grant, r_hit, rd_ok, wr_ok;
    logic [CW-1:0]     cnt [NPORTS];
    logic              unused;

    assign unused = ^{rresp, rlast, bid, bresp};

    assign arlen   = AXI_LEN;
    assign awlen   = AXI_LEN;
    assign arburst = BURST_INCR;
    assign awburst = BURST_INCR;
    assign arlock  = AXI_LOCK;
    assign awlock  = AXI_LOCK;
    assign arcache = AXI_CACHE;
    assign awcache = AXI_CACHE;
    assign arprot  = AXI_PROT;
    assign awprot  = AXI_PROT;
    assign wlast   = 1'b1;
    assign rready  = aresetn;
    assign wr_busy = wr_state != WR_IDLE;
    assign awid    = ID_W'(port_to_id(int'(wr_owner)));
    assign wid     = awid;

    // Reads wait out their own port's write and any write to the same word; writes wait for reads to drain.
    always_comb begin
        rd_elig = '0;
        wr_elig = '0;
        r_hit   = '0;
        for (int p = 0; p < NPORTS; p++) begin
            rd_elig[p] = aresetn && sram_req[p] && !sram_wr[p] && (!arvalid || arready)
                      && (cnt[p] < CW'(RD_OUTST)) && !(wr_busy && wr_owner == PW'(p))
                      && !(wr_busy && awaddr[ADDR_W-1:OFS] == sram_addr[p*ADDR_W+OFS +: ADDR_W-OFS]);
            wr_elig[p] = aresetn && sram_req[p] && sram_wr[p] && !wr_busy && cnt[p] == '0;
            r_hit[p]   = rvalid && rid == ID_W'(port_to_id(p));
        end
    end

    rr_arbiter #(.N(NPORTS)) u_arb (
        .clk   (aclk),
        .rst_n (aresetn),
        .req   (rd_elig | wr_elig),
        .update(|grant),
        .grant (grant)
    );

    always_comb begin
        gidx = '0;
        for (int p = 0; p < NPORTS; p++) if (grant[p]) gidx = PW'(p);
    end

    assign sram_addr_ok = grant;
    assign sram_data_ok = rd_ok | wr_ok;
    assign rd_grant     = grant & rd_elig;
    assign rd_gnt       = |rd_grant;
    assign wr_gnt       = |(grant & wr_elig);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            arvalid <= 1'b0;
            arid    <= '0;
            araddr  <= '0;
            arsize  <= '0;
        end else if (rd_gnt) begin
            arvalid <= 1'b1;
            arid    <= ID_W'(port_to_id(int'(gidx)));
            araddr  <= sram_addr[int'(gidx)*ADDR_W +: ADDR_W];
            arsize  <= {1'b0, sram_size[int'(gidx)*2 +: 2]};
        end else if (arready) begin
            arvalid <= 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_ok      <= '0;
            sram_rdata <= '0;
            for (int p = 0; p < NPORTS; p++) cnt[p] <= '0;
        end else begin
            rd_ok <= r_hit;
            for (int p = 0; p < NPORTS; p++) begin
                if (r_hit[p]) sram_rdata[p*DATA_W +: DATA_W] <= rdata;
                if (rd_grant[p] && !(r_hit[p] && cnt[p] != '0)) cnt[p] <= cnt[p] + 1'b1;
                else if (!rd_grant[p] && r_hit[p] && cnt[p] != '0) cnt[p] <= cnt[p] - 1'b1;
            end
        end
    end

    always_comb begin
        wr_state_nxt = wr_state;
        awvalid      = wr_state == WR_SEND && !aw_done;
        wvalid       = wr_state == WR_SEND && !w_done;
        bready       = wr_state == WR_RESP;
        wr_state_nxt = (wr_state == WR_IDLE && wr_gnt) ? WR_SEND :
                       (wr_state == WR_SEND && (aw_done || awready) && (w_done || wready)) ? WR_RESP :
                       (wr_state == WR_RESP && bvalid) ? WR_IDLE : wr_state;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_state <= WR_IDLE;
            wr_owner <= '0;
            awaddr   <= '0;
            awsize   <= '0;
            wdata    <= '0;
            wstrb    <= '0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            wr_ok    <= '0;
        end else begin
            wr_state <= wr_state_nxt;
            wr_ok    <= '0;
            if (wr_gnt) begin
                wr_owner <= gidx;
                awaddr   <= sram_addr[int'(gidx)*ADDR_W +: ADDR_W];
                awsize   <= {1'b0, sram_size[int'(gidx)*2 +: 2]};
                wdata    <= sram_wdata[int'(gidx)*DATA_W +: DATA_W];
                wstrb    <= sram_wstrb[int'(gidx)*SW +: SW];
                aw_done  <= 1'b0;
                w_done   <= 1'b0;
            end
            if (awvalid && awready) aw_done <= 1'b1;
            if (wvalid && wready) w_done <= 1'b1;
            if (bready && bvalid) begin
                wr_ok[wr_owner] <= 1'b1;
                awaddr          <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sram_axi_bridge.sv
// tb_sram_axi_bridge: directed checks of arbitration, read/write flow, RAW blocking and reset abandonment.
module tb_sram_axi_bridge;

    logic        aclk, aresetn;
    logic [3:0]  arid, awid, wid, rid, bid;
    logic [31:0] araddr, awaddr, wdata, rdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
    logic [3:0]  arcache, awcache, wstrb;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [1:0]  sram_req, sram_wr, sram_addr_ok, sram_data_ok;
    logic [3:0]  sram_size;
    logic [7:0]  sram_wstrb;
    logic [63:0] sram_addr, sram_wdata, sram_rdata;
    int          checks = 0;
    int          fails  = 0;

    sram_axi_bridge dut (
        .aclk(aclk), .aresetn(aresetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .sram_req(sram_req), .sram_wr(sram_wr), .sram_size(sram_size), .sram_wstrb(sram_wstrb),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_addr_ok(sram_addr_ok), .sram_data_ok(sram_data_ok), .sram_rdata(sram_rdata)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rd_req(input int p, input logic [31:0] a);
        sram_req[p]           = 1'b1;
        sram_wr[p]            = 1'b0;
        sram_size[2*p +: 2]   = 2'd2;
        sram_addr[32*p +: 32] = a;
    endtask

    task automatic wr_req(input int p, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        sram_req[p]            = 1'b1;
        sram_wr[p]             = 1'b1;
        sram_size[2*p +: 2]    = 2'd2;
        sram_addr[32*p +: 32]  = a;
        sram_wdata[32*p +: 32] = d;
        sram_wstrb[4*p +: 4]   = s;
    endtask

    task automatic r_beat(input logic v, input logic [3:0] id, input logic [31:0] d);
        rvalid = v;
        rid    = id;
        rdata  = d;
    endtask

    initial begin
        aresetn = 1'b0; arready = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        rvalid = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b1; bid = '0; bresp = '0;
        sram_req = 2'b11; sram_wr = '0; sram_size = '0; sram_wstrb = '0; sram_addr = '0; sram_wdata = '0;
        #1;
        chk("reset_valids", {arvalid, awvalid, wvalid, bready, rready}, 5'b0);
        chk("reset_addr_ok", sram_addr_ok, 2'b00);
        chk("reset_data_ok", sram_data_ok, 2'b00);
        chk("reset_rdata", sram_rdata, 64'h0);
        chk("const_zero", {arlen, awlen, arlock, awlock, arcache, awcache, arprot, awprot}, 38'h0);
        chk("const_burst_wlast", {arburst, awburst, wlast}, 5'b01011);
        repeat (2) @(negedge aclk);
        sram_req = '0; aresetn = 1'b1;
        #1 chk("rready_after_reset", rready, 1'b1);
        // Both ports read together: port 0 first, port 1 next cycle.
        @(negedge aclk); arready = 1'b1; rd_req(0, 32'h100); rd_req(1, 32'h200);
        #1 chk("rr_first_port0", sram_addr_ok, 2'b01);
        @(negedge aclk); sram_req[0] = 1'b0;
        #1 chk("ar0_fields", {arvalid, arid, araddr, arsize}, {1'b1, 4'd0, 32'h100, 3'd2});
        chk("rr_second_port1", sram_addr_ok, 2'b10);
        @(negedge aclk); sram_req[1] = 1'b0;
        #1 chk("ar1_fields", {arvalid, arid, araddr}, {1'b1, 4'd1, 32'h200});
        chk("rr_idle", sram_addr_ok, 2'b00);
        @(negedge aclk); r_beat(1'b1, 4'd0, 32'h11110000);
        #1 chk("ar_dropped", arvalid, 1'b0);
        @(negedge aclk); r_beat(1'b1, 4'd1, 32'h22220001);
        #1 chk("r0_data_ok", sram_data_ok, 2'b01);
        chk("r0_rdata", sram_rdata[31:0], 32'h11110000);
        @(negedge aclk); r_beat(1'b0, 4'd0, 32'h0);
        #1 chk("r1_data_ok", sram_data_ok, 2'b10);
        chk("r1_rdata", sram_rdata[63:32], 32'h22220001);
        // Port 1 issues reads until its outstanding limit.
        @(negedge aclk); rd_req(1, 32'h300);
        #1 chk("data_ok_quiet", sram_data_ok, 2'b00);
        chk("p1_rd1_grant", sram_addr_ok, 2'b10);
        @(negedge aclk); rd_req(1, 32'h304);
        #1 chk("p1_rd1_addr", araddr, 32'h300);
        chk("p1_rd2_grant", sram_addr_ok, 2'b10);
        @(negedge aclk); rd_req(1, 32'h308);
        #1 chk("p1_rd2_addr", {arid, araddr}, {4'd1, 32'h304});
        chk("p1_rd3_stall", sram_addr_ok, 2'b00);
        @(negedge aclk); r_beat(1'b1, 4'd1, 32'hAAAA0001);
        #1 chk("p1_rd3_still_stall", {arvalid, sram_addr_ok}, 3'b000);
        @(negedge aclk); r_beat(1'b1, 4'd1, 32'hAAAA0002);
        #1 chk("p1_resp1_ok", sram_data_ok, 2'b10);
        chk("p1_resp1_data", sram_rdata[63:32], 32'hAAAA0001);
        chk("p1_rd3_grant", sram_addr_ok, 2'b10);
        @(negedge aclk); sram_req[1] = 1'b0; r_beat(1'b1, 4'd1, 32'hAAAA0003);
        #1 chk("p1_resp2_ok", sram_data_ok, 2'b10);
        chk("p1_resp2_data", sram_rdata[63:32], 32'hAAAA0002);
        chk("p1_rd3_addr", {arvalid, araddr}, {1'b1, 32'h308});
        // Port 1 write with AW accepted two cycles ahead of W; port 0 read to same word blocked.
        @(negedge aclk); r_beat(1'b0, 4'd0, 32'h0); wr_req(1, 32'h1000, 32'hDEADBEEF, 4'hF);
        #1 chk("p1_resp3_ok", sram_data_ok, 2'b10);
        chk("p1_resp3_data", sram_rdata[63:32], 32'hAAAA0003);
        chk("wr_grant", sram_addr_ok, 2'b10);
        @(negedge aclk); sram_req[1] = 1'b0; rd_req(0, 32'h1000); awready = 1'b1;
        #1 chk("wr_send_valids", {awvalid, wvalid}, 2'b11);
        chk("wr_fields", {awaddr, awid, wid, wdata, wstrb, awsize}, {32'h1000, 4'd1, 4'd1, 32'hDEADBEEF, 4'hF, 3'd2});
        chk("raw_block_a", {sram_addr_ok, sram_data_ok}, 4'b0000);
        @(negedge aclk); awready = 1'b0;
        #1 chk("aw_done_w_wait", {awvalid, wvalid, sram_addr_ok}, 4'b0100);
        @(negedge aclk); wready = 1'b1;
        #1 chk("w_still_valid", {awvalid, wvalid}, 2'b01);
        @(negedge aclk); wready = 1'b0;
        #1 chk("wr_resp_state", {awvalid, wvalid, bready, sram_addr_ok}, 5'b00100);
        @(negedge aclk); bvalid = 1'b1;
        #1 chk("bready_held", {bready, sram_data_ok}, 3'b100);
        @(negedge aclk); bvalid = 1'b0;
        #1 chk("wr_data_ok", {bready, sram_data_ok}, 3'b010);
        chk("raw_released", sram_addr_ok, 2'b01);
        // Port 0 read in flight while port 1 writes; R and B arrive together.
        @(negedge aclk); sram_req[0] = 1'b0; wr_req(1, 32'h2000, 32'h12345678, 4'h3); awready = 1'b1; wready = 1'b1;
        #1 chk("raw_read_issued", {arvalid, arid, araddr}, {1'b1, 4'd0, 32'h1000});
        chk("wr2_grant", {sram_addr_ok, sram_data_ok}, 4'b1000);
        @(negedge aclk); sram_req[1] = 1'b0;
        #1 chk("wr2_send", {awvalid, wvalid, wstrb, awaddr, wdata}, {2'b11, 4'h3, 32'h2000, 32'h12345678});
        @(negedge aclk); awready = 1'b0; wready = 1'b0; bvalid = 1'b1; r_beat(1'b1, 4'd0, 32'h0BAD0000);
        #1 chk("wr2_same_cycle_done", {awvalid, wvalid, bready}, 3'b001);
        @(negedge aclk); bvalid = 1'b0; r_beat(1'b0, 4'd0, 32'h0);
        #1 chk("r_and_b_data_ok", sram_data_ok, 2'b11);
        chk("r_and_b_rdata", sram_rdata[31:0], 32'h0BAD0000);
        // An R with an ID beyond the port range is dropped.
        @(negedge aclk); r_beat(1'b1, 4'd3, 32'h33333333);
        #1 chk("pulse_ended", sram_data_ok, 2'b00);
        @(negedge aclk); r_beat(1'b0, 4'd0, 32'h0); arready = 1'b0; rd_req(0, 32'h500);
        #1 chk("bad_rid_dropped", {sram_data_ok, sram_rdata}, {2'b00, 32'hAAAA0003, 32'h0BAD0000});
        chk("rd5_grant", sram_addr_ok, 2'b01);
        // Reset while a read waits on AR and a write sits in WR_SEND.
        @(negedge aclk); sram_req[0] = 1'b0; wr_req(1, 32'h600, 32'h0, 4'hF);
        #1 chk("rd5_ar_held", {arvalid, araddr}, {1'b1, 32'h500});
        chk("wr6_grant", sram_addr_ok, 2'b10);
        @(negedge aclk); sram_req[1] = 1'b0;
        #1 chk("pre_reset_valids", {arvalid, awvalid, wvalid}, 3'b111);
        aresetn = 1'b0; sram_req = 2'b11;
        #1 chk("async_reset_valids", {arvalid, awvalid, wvalid, bready, rready}, 5'b0);
        chk("async_reset_sram", {sram_addr_ok, sram_data_ok, sram_rdata}, 68'h0);
        @(negedge aclk); sram_req = '0; aresetn = 1'b1;
        @(negedge aclk); bvalid = 1'b1; r_beat(1'b1, 4'd0, 32'hCAFE0000);
        #1 chk("late_b_not_accepted", {bready, rready}, 2'b01);
        @(negedge aclk); bvalid = 1'b0; r_beat(1'b0, 4'd0, 32'h0); wr_req(0, 32'h700, 32'h0, 4'hF);
        #1 chk("late_b_not_forwarded", sram_data_ok, 2'b01);
        chk("count_zero_after_late_r", sram_addr_ok, 2'b01);
        @(negedge aclk); sram_req = '0;
        #1 chk("post_reset_write", {awvalid, awid, awaddr}, {1'b1, 4'd0, 32'h700});
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
